// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: PC mux selects and fetch controller states.
package pipeline_pkg;

  // PC next-value select, decoded by the PC mux outside the fetch controller
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,  // PC + 4
    PC_BRANCH = 2'b01,  // EX adder branch target
    PC_JUMP   = 2'b10,  // shifted/concatenated jump target
    PC_UNUSED = 2'b11
  } pcSel_e;

  // Fetch controller states (binary encoded)
  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_STALL = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } fetchState_e;

  // Width of the fetch timeout counter
  localparam int TIMEOUT_W = 4;

  // Live redirect select: the branch resolved in EX is older than a jump in ID
  function automatic pcSel_e redirectSel(input logic branchTaken, input logic jump);
    if (branchTaken) begin
      return PC_BRANCH;
    end else if (jump) begin
      return PC_JUMP;
    end
    return PC_SEQ;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory request, PC load
// enable/select and IF/ID latch control. Redirects that arrive while the memory
// has not acked are held pending and applied on the next ack.
module fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imemAck,
  input  logic             branchTaken,
  input  logic             Jump,
  input  logic             loadUseHazard,
  input  logic             haltReq,
  output logic             imemReq,
  output logic             pcWrite,
  output logic [1:0]       pcSel,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             imemErr,
  output logic [CNT_W-1:0] fetchCount
);

  // Last timeout count value before giving up on the memory
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(IMEM_TIMEOUT - 1);

  fetchState_e            stateReg, stateNext;
  logic                   pendValidReg, pendValidNext;
  pcSel_e                 pendSelReg, pendSelNext;
  logic [TIMEOUT_W-1:0]   timeoutReg, timeoutNext;
  logic [CNT_W-1:0]       fetchCountReg, fetchCountNext;

  pcSel_e liveSel;   // redirect requested this cycle
  pcSel_e ackSel;    // redirect to apply when the memory acks

  assign liveSel = redirectSel(branchTaken, Jump);
  // A fresh branch beats a pending redirect; a pending redirect beats a fresh jump
  assign ackSel  = branchTaken  ? PC_BRANCH :
                   pendValidReg ? pendSelReg : liveSel;

  assign fetchCount = fetchCountReg;

  // State, pending redirect, timeout and fetch counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg      <= ST_RST;
      pendValidReg  <= 1'b0;
      pendSelReg    <= PC_SEQ;
      timeoutReg    <= '0;
      fetchCountReg <= '0;
    end else begin
      stateReg      <= stateNext;
      pendValidReg  <= pendValidNext;
      pendSelReg    <= pendSelNext;
      timeoutReg    <= timeoutNext;
      fetchCountReg <= fetchCountNext;
    end
  end

  // Next-state and output decode
  always_comb begin
    stateNext      = stateReg;
    pendValidNext  = pendValidReg;
    pendSelNext    = pendSelReg;
    timeoutNext    = '0;            // cleared unless waiting in FETCH without ack
    fetchCountNext = fetchCountReg;
    imemReq        = 1'b0;
    pcWrite        = 1'b0;
    pcSel          = PC_SEQ;
    ifIdWrite      = 1'b0;
    ifIdFlush      = 1'b0;
    imemErr        = 1'b0;

    case (stateReg)
      ST_RST: begin
        ifIdFlush = 1'b1;
        stateNext = ST_FETCH;
      end

      ST_FETCH: begin
        imemReq = 1'b1;
        if (imemAck) begin
          if (ackSel != PC_SEQ) begin
            // Redirect: load the target and squash the fetched instruction;
            // any hazard this cycle is irrelevant because IF/ID gets a bubble
            pcWrite       = 1'b1;
            pcSel         = ackSel;
            ifIdWrite     = 1'b1;
            ifIdFlush     = 1'b1;
            pendValidNext = 1'b0;
          end else if (loadUseHazard) begin
            stateNext = ST_STALL;
          end else begin
            pcWrite        = 1'b1;
            ifIdWrite      = 1'b1;
            fetchCountNext = fetchCountReg + CNT_W'(1);
            if (haltReq) begin
              stateNext = ST_HALT;
            end
          end
        end else begin
          if (ackSel != PC_SEQ) begin
            pendValidNext = 1'b1;
            pendSelNext   = ackSel;
          end
          if (timeoutReg == TIMEOUT_LAST) begin
            stateNext = ST_ERROR;
          end else begin
            timeoutNext = timeoutReg + TIMEOUT_W'(1);
          end
        end
      end

      ST_STALL: begin
        if (liveSel != PC_SEQ) begin
          pcWrite   = 1'b1;
          pcSel     = liveSel;
          ifIdWrite = 1'b1;
          ifIdFlush = 1'b1;
          stateNext = ST_FETCH;
        end else if (!loadUseHazard) begin
          stateNext = ST_FETCH;   // PC was held, so the same address is re-fetched
        end
      end

      ST_HALT: begin
        // all enables stay low until reset
      end

      ST_ERROR: begin
        imemErr = 1'b1;
      end

      default: begin
        stateNext = ST_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a behavioural model of the fetch rules.
module tb_fetch_ctrl;

  localparam int TIMEOUT = 15;
  localparam int CW      = 4;

  // Model modes
  localparam int M_BOOT    = 0;
  localparam int M_RUN     = 1;
  localparam int M_STALLED = 2;
  localparam int M_HALTED  = 3;
  localparam int M_BROKEN  = 4;

  logic clk = 1'b0;
  logic reset, imemAck, branchTaken, Jump, loadUseHazard, haltReq;
  logic imemReq, pcWrite, ifIdWrite, ifIdFlush, imemErr;
  logic [1:0] pcSel;
  logic [CW-1:0] fetchCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.IMEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .imemAck(imemAck), .branchTaken(branchTaken),
    .Jump(Jump), .loadUseHazard(loadUseHazard), .haltReq(haltReq),
    .imemReq(imemReq), .pcWrite(pcWrite), .pcSel(pcSel), .ifIdWrite(ifIdWrite),
    .ifIdFlush(ifIdFlush), .imemErr(imemErr), .fetchCount(fetchCount)
  );

  logic [10:0] obsVec;
  assign obsVec = {imemReq, pcWrite, pcSel, ifIdWrite, ifIdFlush, imemErr, fetchCount};

  // Model state: mode, pending redirect target (0 = none), wait length, count
  int mMode = M_BOOT, mPendSel = 0, mWait = 0, mCount = 0;
  int nMode, nPendSel, nWait, nCount;
  logic [10:0] expVec;

  task automatic modelEval();
    logic req, pw, wr, fl, err;
    int tgt;
    req = 0; pw = 0; wr = 0; fl = 0; err = 0; tgt = 0;
    nMode = mMode; nPendSel = mPendSel; nWait = 0; nCount = mCount;
    case (mMode)
      M_BOOT: begin
        fl = 1; nMode = M_RUN;
      end
      M_RUN: begin
        req = 1;
        tgt = branchTaken ? 1 : (mPendSel != 0 ? mPendSel : (Jump ? 2 : 0));
        if (imemAck) begin
          if (tgt != 0) begin
            pw = 1; wr = 1; fl = 1; nPendSel = 0;
          end else if (loadUseHazard) begin
            nMode = M_STALLED;
          end else begin
            pw = 1; wr = 1; nCount = (mCount + 1) % (1 << CW);
            if (haltReq) nMode = M_HALTED;
          end
        end else begin
          if (tgt != 0) nPendSel = tgt;
          tgt = 0;   // nothing is loaded into the PC while waiting
          nWait = mWait + 1;
          if (nWait >= TIMEOUT) nMode = M_BROKEN;
        end
      end
      M_STALLED: begin
        tgt = branchTaken ? 1 : (Jump ? 2 : 0);
        if (tgt != 0) begin
          pw = 1; wr = 1; fl = 1; nMode = M_RUN;
        end else if (!loadUseHazard) begin
          nMode = M_RUN;
        end
      end
      M_BROKEN: err = 1;
      default: ;
    endcase
    if (reset) begin
      nMode = M_BOOT; nPendSel = 0; nWait = 0; nCount = 0;
    end
    expVec = {req, pw, 2'(tgt), wr, fl, err, 4'(mCount)};
  endtask

  task automatic setIn(input logic r, input logic a, input logic b, input logic j,
                       input logic h, input logic hz);
    reset = r; imemAck = a; branchTaken = b; Jump = j; haltReq = h; loadUseHazard = hz;
  endtask

  task automatic evalCycle();
    @(negedge clk);
    modelEval();
  endtask

  task automatic commitCycle();
    @(posedge clk);
    mMode = nMode; mPendSel = nPendSel; mWait = nWait; mCount = nCount;
    #1;
  endtask

  task automatic doReset(input int n);
    setIn(1, 0, 0, 0, 0, 0);
    repeat (n) begin
      evalCycle();
      commitCycle();
    end
  endtask

  task automatic test_reset();
    setIn(1, 1, 0, 0, 0, 0);
    evalCycle();
    commitCycle();
    for (int i = 0; i < 2; i++) begin
      evalCycle();
      if (obsVec !== expVec) begin
        errors++; $display("FAIL reset_model cyc%0d: got %b expected %b", i, obsVec, expVec);
      end
      checks++;
      if (ifIdFlush !== 1'b1 || fetchCount !== 4'd0) begin
        errors++; $display("FAIL reset_flush cyc%0d: flush=%b cnt=%0d expected flush=1 cnt=0", i, ifIdFlush, fetchCount);
      end
      checks++;
      commitCycle();
    end
  endtask

  task automatic test_stream();
    setIn(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      evalCycle();
      if (obsVec !== expVec) begin
        errors++; $display("FAIL stream_model cyc%0d: got %b expected %b", i, obsVec, expVec);
      end
      checks++;
      if (i > 0 && (pcWrite !== 1'b1 || pcSel !== 2'b00)) begin
        errors++; $display("FAIL stream_seq cyc%0d: pcWrite=%b pcSel=%b expected 1/00", i, pcWrite, pcSel);
      end
      checks++;
      commitCycle();
    end
    evalCycle();
    if (fetchCount !== 4'd10) begin
      errors++; $display("FAIL stream_count: got %0d expected 10", fetchCount);
    end
    checks++;
    commitCycle();
  endtask

  task automatic test_pending_jump();
    int cnt0;
    for (int i = 0; i < 4; i++) begin
      setIn(0, i == 3, 0, i == 0, 0, 0);
      if (i == 3) cnt0 = mCount;
      evalCycle();
      if (obsVec !== expVec) begin
        errors++; $display("FAIL pendjump_model cyc%0d: got %b expected %b", i, obsVec, expVec);
      end
      checks++;
      if (i < 3 && pcWrite !== 1'b0) begin
        errors++; $display("FAIL pendjump_wait cyc%0d: pcWrite=%b expected 0", i, pcWrite);
      end
      if (i == 3 && (pcWrite !== 1'b1 || pcSel !== 2'b10 || ifIdFlush !== 1'b1 ||
                     fetchCount !== 4'(cnt0))) begin
        errors++; $display("FAIL pendjump_apply: pw=%b sel=%b fl=%b cnt=%0d expected 1/10/1/%0d",
                           pcWrite, pcSel, ifIdFlush, fetchCount, cnt0);
      end
      checks++;
      commitCycle();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      setIn(0, 1, 0, 0, 0, i < 2);
      evalCycle();
      if (obsVec !== expVec) begin
        errors++; $display("FAIL stall_model cyc%0d: got %b expected %b", i, obsVec, expVec);
      end
      checks++;
      if (i < 3 && pcWrite !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc%0d: pcWrite=%b expected 0", i, pcWrite);
      end
      if ((i == 1 || i == 2) && imemReq !== 1'b0) begin
        errors++; $display("FAIL stall_req cyc%0d: imemReq=%b expected 0", i, imemReq);
      end
      if (i == 3 && (pcWrite !== 1'b1 || pcSel !== 2'b00)) begin
        errors++; $display("FAIL stall_resume: pw=%b sel=%b expected 1/00", pcWrite, pcSel);
      end
      checks++;
      commitCycle();
    end
  endtask

  task automatic test_priority();
    setIn(0, 1, 1, 1, 0, 1);
    evalCycle();
    if (obsVec !== expVec) begin
      errors++; $display("FAIL priority_model: got %b expected %b", obsVec, expVec);
    end
    checks++;
    if (pcSel !== 2'b01 || pcWrite !== 1'b1 || ifIdFlush !== 1'b1) begin
      errors++; $display("FAIL priority_sel: sel=%b pw=%b fl=%b expected 01/1/1", pcSel, pcWrite, ifIdFlush);
    end
    checks++;
    commitCycle();
  endtask

  task automatic test_wrap_halt();
    doReset(2);
    setIn(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      evalCycle();
      if (obsVec !== expVec) begin
        errors++; $display("FAIL wrap_model cyc%0d: got %b expected %b", i, obsVec, expVec);
      end
      checks++;
      commitCycle();
    end
    setIn(0, 1, 0, 0, 1, 0);
    evalCycle();
    if (fetchCount !== 4'd1) begin
      errors++; $display("FAIL wrap_count: got %0d expected 1", fetchCount);
    end
    checks++;
    commitCycle();
    for (int i = 0; i < 4; i++) begin
      setIn(0, 1, i == 1, i == 2, 0, 0);
      evalCycle();
      if (obsVec !== expVec) begin
        errors++; $display("FAIL halt_model cyc%0d: got %b expected %b", i, obsVec, expVec);
      end
      checks++;
      if ({imemReq, pcWrite, ifIdWrite, ifIdFlush} !== 4'b0000) begin
        errors++; $display("FAIL halt_enables cyc%0d: got %b expected 0000", i,
                           {imemReq, pcWrite, ifIdWrite, ifIdFlush});
      end
      checks++;
      commitCycle();
    end
  endtask

  task automatic test_timeout();
    doReset(2);
    for (int i = 0; i < 19; i++) begin
      setIn(0, i >= 16, 0, 0, 0, 0);
      evalCycle();
      if (obsVec !== expVec) begin
        errors++; $display("FAIL timeout_model cyc%0d: got %b expected %b", i, obsVec, expVec);
      end
      checks++;
      if (imemErr !== (i >= 16)) begin
        errors++; $display("FAIL timeout_err cyc%0d: imemErr=%b expected %b", i, imemErr, i >= 16);
      end
      checks++;
      commitCycle();
    end
    setIn(1, 0, 0, 0, 0, 0);
    evalCycle();
    commitCycle();
    setIn(0, 0, 0, 0, 0, 0);
    evalCycle();
    if (imemErr !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: imemErr=%b expected 0", imemErr);
    end
    checks++;
    commitCycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      setIn($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0);
      evalCycle();
      if (obsVec !== expVec) begin
        errors++; $display("FAIL random_model cyc%0d: got %b expected %b", i, obsVec, expVec);
      end
      checks++;
      commitCycle();
    end
  endtask

  initial begin
    setIn(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_pending_jump();
    test_stall();
    test_priority();
    test_wrap_halt();
    test_timeout();
    doReset(1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
